vga_scanout: RTL and testbench
==============================

# vga_scanout

Raster scan-out controller placed directly downstream of `video_memory`. It generates 640x480@60 VGA timing from the system clock. Each visible pixel is fetched once through the memory's registered read port (`vx0`/`vy0`/`vr0` → `vo`). Outputs are registered RGB, sync, data-enable and frame status, with sync and DE delayed to line up with the memory read latency.

## Interface
- `CLK_DIV`, 4, system clocks per pixel (100 MHz → 25 MHz); legal range 1..16
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths in lines
- `SYNC_POL`, 0, sync level when asserted (0 = active-low)
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset
- `vx0` out 10: pixel column to memory
- `vy0` out 10: pixel row to memory
- `vr0` out 1: memory read strobe
- `vo` in 24: memory read data, `{R,G,B}`, valid the clk after `vr0`
- `r`, `g`, `b` out 8 each: pixel colour
- `hsync`, `vsync` out 1: sync outputs
- `de` out 1: visible-pixel data enable
- `frame_start` out 1: 1-clk pulse aligned with pixel (0,0) on the outputs
- `vblank` out 1: high while output lines are ≥ `V_ACTIVE`

## Operation
- **Constraints:** H_TOT = sum of the H widths = 800, and must be ≤ 1024. V_TOT = sum of the V widths = 525, and must be ≤ 1024.
- **Divider:** `div` counts 0..CLK_DIV-1 and wraps. `pix_tick` = (`div` == 0).
- **Horizontal counter:** `hcnt` advances at the end of each tick cycle and wraps from H_TOT-1 to 0.
- **Vertical counter:** `vcnt` advances only when `hcnt` wraps, and wraps from V_TOT-1 to 0. It never exceeds V_TOT-1.
- **Active region:** `active` = `hcnt` < H_ACTIVE and `vcnt` < V_ACTIVE.
- **Fetch (combinational from registers):**
  - `vx0` = `hcnt` and `vy0` = `vcnt` when `active`; otherwise both are 0.
  - `vr0` = `pix_tick` & `active` & !`rst`.
  - Exactly one read is issued per visible pixel, H_ACTIVE*V_ACTIVE = 307200 reads per frame.
- **Stage 1** (registered on every clk, tick cycles only):
  - Captures `hs` = (`hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)), i.e. [656, 752).
  - Captures `vs` = (`vcnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)), i.e. [490, 492).
  - Captures `de1` = `active`, `vb1` = (`vcnt` ≥ V_ACTIVE), and `fs1` = (`hcnt` == 0 && `vcnt` == 0 && `pix_tick`).
  - On non-tick cycles stage 1 holds its values, except `fs1`, which clears.
- **Stage 2** (registered on every clk):
  - `{r,g,b}` = `vo` when the stage-1 pixel is a fresh read (`de1`, first cycle after the tick); the value then holds.
  - `{r,g,b}` is forced to 0 when `de1` = 0.
  - `de` = `de1` and `vblank` = `vb1`.
  - `hsync` = `hs` ? SYNC_POL : !SYNC_POL; `vsync` follows the same rule from `vs`.
  - `frame_start` = `fs1`.
- **Reset:**
  - Sets `div` = 0, `hcnt` = 0, `vcnt` = 0, and clears all stage registers.
  - Output values under reset: `r`/`g`/`b` = 0, `de` = 0, `frame_start` = 0, `vblank` = 0, `hsync` = `vsync` = !SYNC_POL, `vr0` = 0.
  - Reset mid-frame abandons the frame with no recovery state. The first clk with `rst` low is a tick cycle fetching (0,0).
- **Memory coordinates:** the memory ignores coordinate bit 0, so 2x2 blocks repeat. This controller still issues every coordinate unmodified.

## Timing
- Read latency is 1 clk (`vr0` at cycle T → `vo` at T+1).
- Output latency is 2 clk. Pixel (x,y) fetched at tick cycle T appears on `r`/`g`/`b`/`de` from T+2 and holds for CLK_DIV clks.
- `hsync`, `vsync`, `vblank` and `frame_start` have the same 2-clk latency, so they are aligned with the colour outputs.
- Pixel period is CLK_DIV clks. Line = 800*CLK_DIV clks (3200). Frame = 420000*CLK_DIV clks (1,680,000).
- With CLK_DIV = 1, every cycle is a tick cycle and the pipeline stays fully aligned.
- No backpressure: `vo` is sampled unconditionally at T+1.

## Test plan
- **Reset:** hold `rst` 5 clks → `vr0` = 0, `de` = 0, `rgb` = 0, `hsync` = `vsync` = 1, `frame_start` = 0 throughout.
- **First pixel:** release `rst`; the memory model returns `vo` = 0xAABBCC one clk after `vr0` at (0,0) → 2 clks after release `r`/`g`/`b` = AA/BB/CC, `de` = 1, `frame_start` = 1 for exactly 1 clk.
- **Horizontal timing:** measure from `de` rise → `de` falls after 2560 clks; `hsync` low starts at 2624 clks and lasts 384 clks; line period is 3200 clks.
- **Line wrap:** at `hcnt` 799 → 0, `vcnt` increments. At `vcnt` 479→480, `vblank` rises 2 clks after that tick and no `vr0` fires for lines 480..524. `vsync` is low for lines 490–491, i.e. 6400 clks.
- **Frame count:** run one full frame → 307200 `vr0` pulses. Each `vr0` has (`vx0`, `vy0`) in range and unique. `frame_start` repeats every 1,680,000 clks.
- **Mid-frame reset:** assert `rst` at pixel (300,200) for 1 clk → outputs take their reset values the next clk. After release, the fetch restarts at (0,0) and `frame_start` follows 2 clks later.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator driving a registered-read video memory,
// with a two-stage pipeline that keeps sync/DE aligned to the returned pixel.
module vga_scanout #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  vx0,
  output logic [9:0]  vy0,
  output logic        vr0,
  input  logic [23:0] vo,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        vblank
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX   = 10'(H_TOT - 1);
  localparam logic [9:0] V_MAX   = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]  r_div;
  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;

  logic        r_hs;
  logic        r_vs;
  logic        r_de1;
  logic        r_vb1;
  logic        r_fs1;
  logic        r_fresh;

  logic [23:0] r_rgb;
  logic        r_de;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_fs;
  logic        r_vblank;

  logic        w_tick;
  logic        w_active;
  logic        w_hs;
  logic        w_vs;

  assign w_tick   = (r_div == 4'd0);
  assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs     = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
  assign w_vs     = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);

  assign vx0 = w_active ? r_hcnt : 10'd0;
  assign vy0 = w_active ? r_vcnt : 10'd0;
  assign vr0 = w_tick & w_active & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= 4'd0;
      r_hcnt <= 10'd0;
      r_vcnt <= 10'd0;
    end else begin
      r_div <= (r_div == DIV_MAX) ? 4'd0 : r_div + 4'd1;
      if (w_tick) begin
        if (r_hcnt == H_MAX) begin
          r_hcnt <= 10'd0;
          r_vcnt <= (r_vcnt == V_MAX) ? 10'd0 : r_vcnt + 10'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end
      end
    end
  end

  // Stage 1: timing flags captured alongside the read request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_de1   <= 1'b0;
      r_vb1   <= 1'b0;
      r_fs1   <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      r_fresh <= w_tick;
      r_fs1   <= w_tick && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
      if (w_tick) begin
        r_hs  <= w_hs;
        r_vs  <= w_vs;
        r_de1 <= w_active;
        r_vb1 <= (r_vcnt >= V_ACT);
      end
    end
  end

  // Stage 2: vo is only meaningful the clk after a tick, so latch it then.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb    <= 24'd0;
      r_de     <= 1'b0;
      r_hsync  <= ~SYNC_POL;
      r_vsync  <= ~SYNC_POL;
      r_fs     <= 1'b0;
      r_vblank <= 1'b0;
    end else begin
      if (!r_de1) begin
        r_rgb <= 24'd0;
      end else if (r_fresh) begin
        r_rgb <= vo;
      end
      r_de     <= r_de1;
      r_hsync  <= r_hs ? SYNC_POL : ~SYNC_POL;
      r_vsync  <= r_vs ? SYNC_POL : ~SYNC_POL;
      r_fs     <= r_fs1;
      r_vblank <= r_vb1;
    end
  end

  assign r           = r_rgb[23:16];
  assign g           = r_rgb[15:8];
  assign b           = r_rgb[7:0];
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_fs;
  assign vblank      = r_vblank;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: random-reset scoreboard bench; expected outputs come from
// a closed-form raster position computed from clocks since reset release.
module tb_vga_scanout;

  localparam int   D    = 3;
  localparam int   HA   = 16;
  localparam int   HFP  = 2;
  localparam int   HSY  = 3;
  localparam int   HBP  = 3;
  localparam int   VA   = 8;
  localparam int   VFP  = 1;
  localparam int   VSY  = 2;
  localparam int   VBP  = 2;
  localparam logic POL  = 1'b0;
  localparam int   HT   = HA + HFP + HSY + HBP;
  localparam int   VT   = VA + VFP + VSY + VBP;
  localparam int   FRAME = HT * VT * D;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        vb;
    logic        fs;
    logic        vr;
    logic [9:0]  vx;
    logic [9:0]  vy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [9:0]  vx0;
  logic [9:0]  vy0;
  logic        vr0;
  logic [23:0] vo;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  logic        vblank;

  logic [23:0] mem [HA*VA];
  exp_t        q[$];
  int          tests;
  int          fails;
  int          m;
  bit          done;

  vga_scanout #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst(rst),
    .vx0(vx0), .vy0(vy0), .vr0(vr0), .vo(vo),
    .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .vblank(vblank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: registered read; garbage on cycles without a read.
  always @(posedge clk) begin
    if (vr0 && vx0 < 10'(HA) && vy0 < 10'(VA))
      vo <= mem[int'(vy0) * HA + int'(vx0)];
    else
      vo <= 24'($urandom);
  end

  // m = consecutive rising edges that sampled rst low.
  function automatic exp_t model(input int mm, input logic rr);
    exp_t e;
    int p, h, v, qq, ph;
    e    = '0;
    e.hs = ~POL;
    e.vs = ~POL;
    p = (mm + D - 1) / D;
    h = p % HT;
    v = (p / HT) % VT;
    if (h < HA && v < VA) begin
      e.vx = 10'(h);
      e.vy = 10'(v);
      e.vr = !rr && (mm % D == 0);
    end
    if (mm >= 2) begin
      qq = (mm - 2) / D;
      ph = (mm - 2) % D;
      h  = qq % HT;
      v  = (qq / HT) % VT;
      e.de  = (h < HA) && (v < VA);
      e.rgb = e.de ? mem[v * HA + h] : 24'd0;
      e.hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? POL : ~POL;
      e.vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? POL : ~POL;
      e.vb  = (v >= VA);
      e.fs  = (h == 0) && (v == 0) && (ph == 0);
    end
    return e;
  endfunction

  task automatic step(input logic rnext);
    @(posedge clk);
    m = rst ? 0 : m + 1;
    #1;
    rst = rnext;
    q.push_back(model(m, rnext));
  endtask

  // Monitor: per-cycle compare plus whole-frame read accounting.
  initial begin : monitor
    exp_t e;
    exp_t a;
    bit   seen [HA*VA];
    bit   armed;
    int   nrd;
    int   ndup;
    int   cyc;
    int   last_fs;
    armed = 0;
    nrd = 0;
    ndup = 0;
    cyc = 0;
    last_fs = 0;
    foreach (seen[i]) seen[i] = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{rgb: {r, g, b}, de: de, hs: hsync, vs: vsync, vb: vblank,
              fs: frame_start, vr: vr0, vx: vx0, vy: vy0};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL cycle m=%0d got rgb=%h de=%b hs=%b vs=%b vb=%b fs=%b vr=%b x=%0d y=%0d expected rgb=%h de=%b hs=%b vs=%b vb=%b fs=%b vr=%b x=%0d y=%0d",
                   m, a.rgb, a.de, a.hs, a.vs, a.vb, a.fs, a.vr, a.vx, a.vy,
                   e.rgb, e.de, e.hs, e.vs, e.vb, e.fs, e.vr, e.vx, e.vy);
        end
      end
      if (rst) begin
        armed = 0;
      end else if (frame_start) begin
        if (armed) begin
          tests++;
          if (cyc - last_fs != FRAME || nrd != HA * VA || ndup != 0) begin
            fails++;
            $display("FAIL frame period=%0d reads=%0d dups=%0d expected period=%0d reads=%0d dups=0",
                     cyc - last_fs, nrd, ndup, FRAME, HA * VA);
          end
        end
        armed = 1;
        last_fs = cyc;
        nrd = 0;
        ndup = 0;
        foreach (seen[i]) seen[i] = 0;
      end
      if (vr0) begin
        nrd++;
        if (vx0 >= 10'(HA) || vy0 >= 10'(VA)) ndup++;
        else if (seen[int'(vy0) * HA + int'(vx0)]) ndup++;
        else seen[int'(vy0) * HA + int'(vx0)] = 1;
      end
    end
  end

  initial begin : driver
    int n;
    int k;
    tests = 0;
    fails = 0;
    done = 0;
    m = 0;
    rst = 1'b1;
    foreach (mem[i]) mem[i] = 24'($urandom);
    mem[0] = 24'hAABBCC;
    repeat (5) step(1'b1);
    repeat (2 * FRAME + 50) step(1'b0);
    for (int i = 0; i < 3; i++) begin
      n = $urandom_range(50, FRAME);
      repeat (n) step(1'b0);
      k = (i == 0) ? 1 : $urandom_range(1, 3);
      repeat (k) step(1'b1);
    end
    repeat (FRAME + 20) step(1'b0);
    @(negedge clk);
    #1;
    done = 1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

endmodule
